// File: rtl/deaccum_pkg.sv
// deaccum_pkg: shared definitions for the de-accumulator block.
//   fifo_state_t : occupancy states of the 2-entry output buffer
//   N_DEF        : default data width (running sum / difference)
//   CW_DEF       : default accepted-sample counter width
package deaccum_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_t;

  localparam int N_DEF  = 6;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry output buffer with valid/ready handshake on the read
// side. The FSM state is the occupancy, so full/valid come straight from a
// register and no combinational path runs from out_ready to the write side.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush (empties buffer, zeroes entries)
//   push, din   : write strobe and data (must not be asserted when full)
//   out_ready   : downstream accepts dout this cycle
//   out_valid   : dout holds the oldest buffered entry
//   dout        : oldest entry, forced to 0 when empty
//   full        : both entries occupied
module skid_fifo2
  import deaccum_pkg::*;
#(
  parameter int W = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic         full
);

  fifo_state_t  state, state_nxt;
  logic [W-1:0] ent0;  // head (oldest)
  logic [W-1:0] ent1;  // second entry, only meaningful in TWO
  logic         pop;

  assign out_valid = (state != EMPTY);
  assign full      = (state == TWO);
  assign pop       = out_valid & out_ready;
  assign dout      = out_valid ? ent0 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (!push && pop) state_nxt = EMPTY;
      end
      TWO:   if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (clear) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
    end else if (clear) begin
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) ent0 <= din;
        ONE: begin
          if (push && pop) begin
            ent0 <= din;
          end else if (push) begin
            ent1 <= din;
          end else if (pop) begin
            ent0 <= '0;
          end
        end
        TWO: begin
          // Pushes are never offered in TWO; a pop shifts the queue forward.
          if (pop) begin
            ent0 <= ent1;
            ent1 <= '0;
          end
        end
        default: begin
          ent0 <= '0;
          ent1 <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/deaccum.sv
// deaccum: inverts an accumulator stage. Each accepted running-sum sample
// produces Data - Prev (mod 2^n), then Prev takes Data. Prev starts at 0 so a
// stream from a zero-reset accumulator is reconstructed exactly, wrap included.
//   Clk, Resetn        : clock, asynchronous active-low reset
//   En                 : enable input acceptance (buffered output still drains)
//   Clear              : synchronous flush of Prev, buffer and Count
//   InValid/InReady    : input handshake, Data is the running sum
//   OutValid/OutReady  : output handshake, Q is the reconstructed increment
//   Count              : accepted samples since reset/Clear, saturating
module deaccum
  import deaccum_pkg::*;
#(
  parameter int n  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic          En,
  input  logic          Clear,
  input  logic          InValid,
  output logic          InReady,
  input  logic [n-1:0]  Data,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [n-1:0]  Q,
  output logic [CW-1:0] Count
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  logic         armed;   // low during reset and until the first edge after it
  logic         full;
  logic         accept;
  logic [n-1:0] prev;
  logic [n-1:0] diff_p0;

  // Ready depends only on registered state plus En/Clear, never on OutReady.
  assign InReady = armed & En & ~Clear & ~full;
  assign accept  = InValid & InReady;
  assign diff_p0 = Data - prev;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      prev  <= '0;
      Count <= '0;
    end else if (Clear) begin
      prev  <= '0;
      Count <= '0;
    end else if (accept) begin
      prev  <= Data;
      Count <= sat_inc(Count);
    end
  end

  // stage boundary: difference registered into the output buffer
  skid_fifo2 #(
    .W(n)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Resetn),
    .clear     (Clear),
    .push      (accept),
    .din       (diff_p0),
    .out_ready (OutReady),
    .out_valid (OutValid),
    .dout      (Q),
    .full      (full)
  );

endmodule

// File: tb/tb_deaccum.sv
module tb_deaccum;

  logic        Clk = 1'b0;
  logic        Resetn;
  logic        En;
  logic        Clear;
  logic        InValid;
  logic        InReady;
  logic [5:0]  Data;
  logic        OutValid;
  logic        OutReady;
  logic [5:0]  Q;
  logic [15:0] Count;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  deaccum #(.n(6), .CW(16)) dut (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .En       (En),
    .Clear    (Clear),
    .InValid  (InValid),
    .InReady  (InReady),
    .Data     (Data),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Q        (Q),
    .Count    (Count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    Resetn = 1'b0; En = 1'b1; Clear = 1'b0; InValid = 1'b0;
    Data = 6'd0; OutReady = 1'b1;
    #12;
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_q",        32'(Q),        32'd0);
    chk("rst_inready",  32'(InReady),  32'd0);
    chk("rst_count",    32'(Count),    32'd0);
    Resetn = 1'b1;
    tick();
    chk("rel_inready", 32'(InReady), 32'd1);

    // basic inversion: 2,6,13 -> 2,4,7
    InValid = 1'b1; Data = 6'd2;  tick(); chk("inv_q0", 32'(Q), 32'd2);
    chk("inv_v0", 32'(OutValid), 32'd1);
    Data = 6'd6;  tick(); chk("inv_q1", 32'(Q), 32'd4);
    Data = 6'd13; tick(); chk("inv_q2", 32'(Q), 32'd7);
    InValid = 1'b0; tick();
    chk("inv_count", 32'(Count), 32'd3);
    chk("inv_drain", 32'(OutValid), 32'd0);
    chk("inv_qzero", 32'(Q), 32'd0);

    // wrap-around: 60, 3 -> 60, 7
    Clear = 1'b1; tick(); Clear = 1'b0;
    InValid = 1'b1; Data = 6'd60; tick(); chk("wrap_q0", 32'(Q), 32'd60);
    Data = 6'd3; tick(); chk("wrap_q1", 32'(Q), 32'd7);
    InValid = 1'b0; tick();

    // backpressure: 5, 9, 20 with OutReady low
    Clear = 1'b1; tick(); Clear = 1'b0;
    OutReady = 1'b0;
    InValid = 1'b1; Data = 6'd5; tick();
    chk("bp_q_a", 32'(Q), 32'd5);
    chk("bp_rdy_a", 32'(InReady), 32'd1);
    Data = 6'd9; tick();
    chk("bp_rdy_b", 32'(InReady), 32'd0);
    chk("bp_q_b", 32'(Q), 32'd5);
    Data = 6'd20; tick();
    chk("bp_q_hold", 32'(Q), 32'd5);
    chk("bp_cnt_hold", 32'(Count), 32'd2);
    OutReady = 1'b1; tick();
    chk("bp_q1", 32'(Q), 32'd4);
    chk("bp_rdy_c", 32'(InReady), 32'd1);
    tick();
    chk("bp_q2", 32'(Q), 32'd11);
    InValid = 1'b0; tick();
    chk("bp_drain", 32'(OutValid), 32'd0);
    chk("bp_count", 32'(Count), 32'd3);

    // Clear while TWO with InValid high
    OutReady = 1'b0; InValid = 1'b1;
    Data = 6'd1; tick();
    Data = 6'd2; tick();
    chk("clr_full", 32'(InReady), 32'd0);
    Clear = 1'b1; Data = 6'd50; tick();
    chk("clr_valid", 32'(OutValid), 32'd0);
    chk("clr_count", 32'(Count), 32'd0);
    Clear = 1'b0; OutReady = 1'b1; Data = 6'd7; tick();
    chk("clr_q", 32'(Q), 32'd7);
    chk("clr_count1", 32'(Count), 32'd1);
    InValid = 1'b0; tick();

    // En low for 3 cycles with InValid high
    En = 1'b0; InValid = 1'b1; Data = 6'd9; #1;
    chk("en_rdy", 32'(InReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_novalid", 32'(OutValid), 32'd0);
      chk("en_count", 32'(Count), 32'd1);
    end
    En = 1'b1; tick();
    chk("en_resume_q", 32'(Q), 32'd2);
    chk("en_resume_cnt", 32'(Count), 32'd2);
    InValid = 1'b0; tick();

    // asynchronous reset while ONE
    OutReady = 1'b0; InValid = 1'b1; Data = 6'd12; tick();
    chk("ar_pre_q", 32'(Q), 32'd3);
    InValid = 1'b0;
    #2; Resetn = 1'b0; #1;
    chk("ar_valid", 32'(OutValid), 32'd0);
    chk("ar_q", 32'(Q), 32'd0);
    chk("ar_rdy", 32'(InReady), 32'd0);
    chk("ar_count", 32'(Count), 32'd0);
    #1; Resetn = 1'b1;
    tick();
    chk("ar_rel_rdy", 32'(InReady), 32'd1);
    chk("ar_rel_valid", 32'(OutValid), 32'd0);
    OutReady = 1'b1; InValid = 1'b1; Data = 6'd10; tick();
    chk("ar_q10", 32'(Q), 32'd10);
    InValid = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
